// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin write arbiter that shares one synchronous FIFO
//               write port between NUM_REQ producers. It registers a one-hot
//               grant, muxes the owner's data onto fifo_datain and pulses
//               fifo_wt_en for every accepted beat. Writing stalls while
//               fifo_full is high.
//               Optional macro FIFO_ARB_BURST_EN: the grant is held for up
//               to BURST_LEN beats instead of a single beat.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] data_in,
    input  logic                  fifo_full,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  fifo_wt_en,
    output logic [DW-1:0]         fifo_datain,
    output logic [NUM_REQ-1:0]    beat_ack
);

    localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // Stop elaboration on a configuration the arbiter is not built for.
    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BURST_LEN < 1) || (BURST_LEN > 15)) begin : g_param_check
            $error("fifo_wr_arbiter: NUM_REQ or BURST_LEN out of range");
        end
    endgenerate

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [c_IW-1:0]    r_last_ptr;

    logic [c_IW-1:0]    w_gidx;
    logic               w_req_g;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_release;
    logic [c_IW-1:0]    w_search_ptr;
    logic [c_IW-1:0]    w_next_idx;
    logic               w_found;
    logic [NUM_REQ-1:0] w_next_gnt;
    logic [DW-1:0]      w_data;

`ifdef FIFO_ARB_BURST_EN
    logic [3:0]         r_beat_cnt;
`endif

    // Index of the current owner, decoded from the one-hot grant.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_gidx = c_IW'(i);
            end
        end
    end

    // Owner still requesting, and whether a beat is written this cycle.
    // Reset kills the write combinationally so no beat leaks out mid-reset.
    assign w_req_g = |(r_gnt & req);
    assign w_beat  = w_req_g & ~fifo_full & ~rst;

`ifdef FIFO_ARB_BURST_EN
    assign w_last_beat = (r_beat_cnt == 4'(BURST_LEN - 1));
`else
    assign w_last_beat = 1'b1;
`endif

    // Ownership ends after the final beat of a grant or when the owner withdraws.
    assign w_release = ~w_req_g | (w_beat & w_last_beat);

    // On release the owner's index becomes the new rotation pointer this very
    // edge, so the search starts from it to give back-to-back grants.
    assign w_search_ptr = (r_state == S_OWN) ? w_gidx : r_last_ptr;

    // Round-robin search: first request found after the pointer, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_next_idx = w_search_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[c_IW'((int'(w_search_ptr) + k) % NUM_REQ)]) begin
                w_found    = 1'b1;
                w_next_idx = c_IW'((int'(w_search_ptr) + k) % NUM_REQ);
            end
        end
    end

    // One-hot form of the search result (all zero when nobody requests).
    always_comb begin
        w_next_gnt = '0;
        w_next_gnt[w_next_idx] = w_found;
    end

    // Data mux: slice of the granted requester, zero with no owner.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_data = w_data | data_in[i*DW +: DW];
            end
        end
    end

    // Arbitration FSM: grant, rotation pointer and burst beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_last_ptr <= c_IW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            r_beat_cnt <= 4'd0;
`endif
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_gnt   <= w_next_gnt;
                r_state <= S_OWN;
            end
        end else begin
            if (w_release) begin
                r_last_ptr <= w_gidx;
                r_gnt      <= w_next_gnt;
                r_state    <= w_found ? S_OWN : S_IDLE;
`ifdef FIFO_ARB_BURST_EN
                r_beat_cnt <= 4'd0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
`endif
            end
        end
    end

    assign gnt         = r_gnt;
    assign fifo_wt_en  = w_beat;
    assign beat_ack    = r_gnt & {NUM_REQ{w_beat}};
    assign fifo_datain = rst ? '0 : w_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter (4 x 8-bit).
//               Expected grants, writes and data are hand-derived constants.
//               Rotation, single-requester streaming, full stalls, withdraw
//               and mid-transfer reset run in the default build; the
//               alternating / burst sequence adapts to FIFO_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] data_in;
    logic                  fifo_full;
    logic [NUM_REQ-1:0]    gnt;
    logic                  fifo_wt_en;
    logic [DW-1:0]         fifo_datain;
    logic [NUM_REQ-1:0]    beat_ack;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DW        (DW),
        .BURST_LEN (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .gnt         (gnt),
        .fifo_wt_en  (fifo_wt_en),
        .fifo_datain (fifo_datain),
        .beat_ack    (beat_ack)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle, then compare every output.
    task automatic chk_port(input string tag, input logic [3:0] eg, input logic ewe,
                            input logic [7:0] ed, input logic [3:0] eack);
        #1;
        chk({tag, ".gnt"},    32'(gnt),         32'(eg));
        chk({tag, ".wt_en"},  32'(fifo_wt_en),  32'(ewe));
        chk({tag, ".data"},   32'(fifo_datain), 32'(ed));
        chk({tag, ".ack"},    32'(beat_ack),    32'(eack));
    endtask

    function automatic logic [7:0] dat_of(input logic [3:0] g);
        case (g)
            4'b0001: return 8'h11;
            4'b0010: return 8'h22;
            4'b0100: return 8'hA5;
            4'b1000: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [3:0] rr [5];
        logic [3:0] g;
        rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000; rr[4] = 4'b0001;

        rst       = 1'b1;
        req       = 4'b1111;
        fifo_full = 1'b0;
        data_in   = {8'h44, 8'hA5, 8'h22, 8'h11};

        // Reset held two cycles with all requests up.
        tick;
        tick;
        chk_port("reset", 4'b0000, 1'b0, 8'h00, 4'b0000);

`ifndef FIFO_ARB_BURST_EN
        // Rotation: one beat per grant, req[0] first.
        rst = 1'b0;
        chk_port("idle", 4'b0000, 1'b0, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk_port("rr", rr[i], 1'b1, dat_of(rr[i]), rr[i]);
        end

        // Single requester streams one write per cycle.
        req = 4'b0100;
        chk_port("single_wd", 4'b0001, 1'b0, 8'h11, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_port("single", 4'b0100, 1'b1, 8'hA5, 4'b0100);
        end

        // Full stall holds grant 0010 three cycles, then one write and rotate.
        req       = 4'b0010;
        fifo_full = 1'b1;
        chk_port("full_wd", 4'b0100, 1'b0, 8'hA5, 4'b0000);
        tick;
        chk_port("full0", 4'b0010, 1'b0, 8'h22, 4'b0000);
        req = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk_port("full_hold", 4'b0010, 1'b0, 8'h22, 4'b0000);
        end
        fifo_full = 1'b0;
        chk_port("full_go", 4'b0010, 1'b1, 8'h22, 4'b0010);
        tick;
        fifo_full = 1'b1;
        req       = 4'b1001;
        chk_port("full_rot", 4'b1000, 1'b0, 8'h44, 4'b0000);

        // Owner 3 withdraws before any beat: no write, grant moves to 0.
        req       = 4'b0001;
        fifo_full = 1'b0;
        chk_port("withdraw", 4'b1000, 1'b0, 8'h44, 4'b0000);
        tick;
        chk_port("withdraw_next", 4'b0001, 1'b1, 8'h11, 4'b0001);

        // Reset during an active write to requester 3.
        req = 4'b1000;
        chk_port("pre_rst_wd", 4'b0001, 1'b0, 8'h11, 4'b0000);
        tick;
        chk_port("pre_rst", 4'b1000, 1'b1, 8'h44, 4'b1000);
        rst = 1'b1;
        req = 4'b1001;
        chk_port("mid_rst", 4'b1000, 1'b0, 8'h00, 4'b0000);
        tick;
        chk_port("mid_rst_next", 4'b0000, 1'b0, 8'h00, 4'b0000);
        rst = 1'b0;
        tick;
        chk_port("post_rst", 4'b0001, 1'b1, 8'h11, 4'b0001);

        // Two continuous requesters alternate every beat.
        rst = 1'b1;
        tick;
`endif

        // Fresh start with requesters 0 and 1 continuously active.
        rst = 1'b0;
        req = 4'b0011;
        chk_port("pair_idle", 4'b0000, 1'b0, 8'h00, 4'b0000);
`ifndef FIFO_ARB_BURST_EN
        for (int i = 0; i < 6; i++) begin
            tick;
            g = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            chk_port("alt", g, 1'b1, dat_of(g), g);
        end
`else
        // Four beats per owner, repeating.
        for (int i = 0; i < 12; i++) begin
            tick;
            g = ((i / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
            chk_port("burst", g, 1'b1, dat_of(g), g);
        end
        // Two beats of owner 1, a two-cycle stall, then its last two beats.
        for (int i = 0; i < 2; i++) begin
            tick;
            chk_port("burst_pre", 4'b0010, 1'b1, 8'h22, 4'b0010);
        end
        tick;
        fifo_full = 1'b1;
        chk_port("burst_stall", 4'b0010, 1'b0, 8'h22, 4'b0000);
        tick;
        chk_port("burst_stall2", 4'b0010, 1'b0, 8'h22, 4'b0000);
        fifo_full = 1'b0;
        chk_port("burst_resume", 4'b0010, 1'b1, 8'h22, 4'b0010);
        tick;
        chk_port("burst_last", 4'b0010, 1'b1, 8'h22, 4'b0010);
        tick;
        chk_port("burst_rot", 4'b0001, 1'b1, 8'h11, 4'b0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net: never let the run hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
